// File: rtl/s_capture_pkg.sv
// s_capture_pkg: shared definitions for the capture controller slice.
//   - default buffer address / sample widths
//   - controller state encoding (IDLE=0 .. DONE=4) and the typed state enum built on it
package s_capture_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        StIdle = ST_IDLE,
        StPre  = ST_PRE,
        StWait = ST_WAIT,
        StPost = ST_POST,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/s_capture_ram.sv
// s_capture_ram: simple dual-port sample buffer, 2**ADDR_W x DATA_W.
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset (clears the read register only)
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read port; rdata_o is registered and updates 1 cycle after re_i
//   rdata_o          read data, holds its value when re_i is low
module s_capture_ram
    import s_capture_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/s_capture_ctrl.sv
// s_capture_ctrl: acquisition controller. Streams Valid samples into a circular buffer,
// keeps PreCount samples ahead of the trigger sample, fills the rest of the frame after it,
// then serves the frame oldest-first through a request/valid read port.
// Ports:
//   Clk, Reset            clock; synchronous active-high reset
//   Input, Valid          sample stream
//   Trigger               trigger level; rising edge sampled on Valid
//   Arm, Force            start acquisition / immediate trigger while waiting (pulses)
//   PreCount              pre-trigger samples, latched on accepted Arm
//   Busy, Done            acquisition in progress / frame readable
//   TrigAddr              buffer address of the trigger sample
//   RdReq                 pop one sample (DONE only)
//   RdData, RdValid, RdLast   read data, 1 cycle after accepted RdReq; RdLast on last sample
// Build option S_CAPTURE_AUTO_EN: adds parameter AUTO_W and output AutoTrig; a Valid-counted
// timer in WAIT fires a forced trigger when it reaches all-ones.
module s_capture_ctrl
    import s_capture_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
`ifdef S_CAPTURE_AUTO_EN
    ,
    parameter int unsigned AUTO_W = 24
`endif
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Input,
    input  logic              Valid,
    input  logic              Trigger,
    input  logic              Arm,
    input  logic              Force,
    input  logic [ADDR_W-1:0] PreCount,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] TrigAddr,
    input  logic              RdReq,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              RdLast
`ifdef S_CAPTURE_AUTO_EN
    ,
    output logic              AutoTrig
`endif
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0]   Depth   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CntW-1:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    // Samples still to be written after the current one, including a pending forced trigger.
    logic [CntW-1:0]   post_q, post_d;
    logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
    logic              trig_prev_q, trig_prev_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              wr_en, rd_en;
    logic              edge_det, force_any;

`ifdef S_CAPTURE_AUTO_EN
    localparam logic [AUTO_W-1:0] AutoOne = {{(AUTO_W-1){1'b0}}, 1'b1};
    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              auto_trig_q, auto_trig_d;
    logic              auto_fire;

    assign auto_fire = (state_q == StWait) && (&auto_cnt_q);
    assign force_any = Force | auto_fire;
`else
    assign force_any = Force;
`endif

    assign edge_det = Valid & Trigger & ~trig_prev_q;

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_ptr_d    = rd_ptr_q;
        trig_addr_d = trig_addr_q;
        pre_d       = pre_q;
        fill_d      = fill_q;
        post_d      = post_q;
        rd_cnt_d    = rd_cnt_q;
        trig_prev_d = Valid ? Trigger : trig_prev_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
`ifdef S_CAPTURE_AUTO_EN
        auto_trig_d = auto_trig_q;
        auto_cnt_d  = '0;
        if (state_q == StWait) begin
            auto_cnt_d = Valid ? auto_cnt_q + AutoOne : auto_cnt_q;
        end
`endif

        unique case (state_q)
            StIdle, StDone: begin
                // Arm takes priority over a same-cycle read request.
                if (Arm) begin
                    pre_d   = PreCount;
                    fill_d  = '0;
                    state_d = (PreCount == '0) ? StWait : StPre;
`ifdef S_CAPTURE_AUTO_EN
                    auto_trig_d = 1'b0;
`endif
                end else if (state_q == StDone && RdReq && rd_cnt_q != Depth) begin
                    rd_en      = 1'b1;
                    rd_ptr_d   = rd_ptr_q + AddrOne;
                    rd_cnt_d   = rd_cnt_q + CntOne;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rd_cnt_q == Depth - CntOne);
                end
            end
            StPre: begin
                if (Valid) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + AddrOne;
                    fill_d    = fill_q + AddrOne;
                    if (fill_d == pre_q) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (Valid) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + AddrOne;
                end
                if (edge_det || force_any) begin
                    trig_addr_d = wr_addr_q;
                    // Without Valid the trigger sample is still to come.
                    post_d = Depth - {1'b0, pre_q} - {{ADDR_W{1'b0}}, Valid};
`ifdef S_CAPTURE_AUTO_EN
                    auto_trig_d = auto_fire & ~edge_det & ~Force;
`endif
                    if (post_d == '0) begin
                        state_d  = StDone;
                        rd_ptr_d = trig_addr_d - pre_q;
                        rd_cnt_d = '0;
                    end else begin
                        state_d = StPost;
                    end
                end
            end
            StPost: begin
                if (Valid) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + AddrOne;
                    post_d    = post_q - CntOne;
                    if (post_d == '0) begin
                        state_d  = StDone;
                        rd_ptr_d = trig_addr_q - pre_q;
                        rd_cnt_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            wr_addr_q   <= '0;
            rd_ptr_q    <= '0;
            trig_addr_q <= '0;
            pre_q       <= '0;
            fill_q      <= '0;
            post_q      <= '0;
            rd_cnt_q    <= '0;
            trig_prev_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_addr_q <= trig_addr_d;
            pre_q       <= pre_d;
            fill_q      <= fill_d;
            post_q      <= post_d;
            rd_cnt_q    <= rd_cnt_d;
            trig_prev_q <= trig_prev_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

`ifdef S_CAPTURE_AUTO_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            auto_cnt_q  <= '0;
            auto_trig_q <= 1'b0;
        end else begin
            auto_cnt_q  <= auto_cnt_d;
            auto_trig_q <= auto_trig_d;
        end
    end

    assign AutoTrig = auto_trig_q & (state_q == StDone);
`endif

    s_capture_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .we_i   (wr_en),
        .waddr_i(wr_addr_q),
        .wdata_i(Input),
        .re_i   (rd_en),
        .raddr_i(rd_ptr_q),
        .rdata_o(RdData)
    );

    assign Busy     = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
    assign Done     = (state_q == StDone);
    assign TrigAddr = trig_addr_q;
    assign RdValid  = rd_valid_q;
    assign RdLast   = rd_last_q;

endmodule
